ps2_ascii_fifo: RTL and testbench

- Next-generation keyboard decode stage. It consumes the framed PS/2 byte stream from the receiver (`i_byte_en`/`i_byte`) and tracks make, break and extended prefixes. It maintains shift and caps-lock state, translates set-2 scancodes to ASCII, and buffers characters in a parametrised FIFO.
- It replaces the single-register keydown/shift_key/scancode2ascii chain, so consumers no longer lose keys when they are slow.
- Characters leave through a valid/ready handshake, for a UART or display writer downstream.

---
 rtl/ps2_ascii_fifo.sv | 199 +++++++++++++++++++
 tb/tb_ps2_ascii_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_fifo.sv
// PS/2 set-2 decoder: make/break/extended prefix tracking, shift and caps-lock state, ASCII FIFO.
// Optional macro KB_EXT_EN adds cursor keys, keypad enter and delete to the translation.
module ps2_ascii_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_byte_en,
    input  logic [7:0]        i_byte,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [7:0]        o_ascii,
    output logic [ADDR_W:0]   o_count,
    output logic              o_shift,
    output logic              o_capslock,
    output logic              o_overflow
);
    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    state_t            state_reg;
    logic              shift_l_reg;
    logic              shift_r_reg;
    logic              caps_reg;
    logic              caps_held_reg;
    logic              char_valid_reg;
    logic [7:0]        char_reg;

    logic              make_evt;
    logic              break_evt;
    logic              evt_ext;
    logic              xlat_hit;
    logic [7:0]        xlat_char;
    logic [7:0]        letter_lc;
    logic              shift_now;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic              overflow_reg;
    logic              full;
    logic              pop;
    logic              push_ok;

    assign shift_now = shift_l_reg | shift_r_reg;

    // A byte completes a key event unless it is a prefix that moves the decoder on.
    always_comb begin
        make_evt  = 1'b0;
        break_evt = 1'b0;
        evt_ext   = (state_reg == GOT_E0) || (state_reg == GOT_E0F0);
        if (i_byte_en) begin
            case (state_reg)
                IDLE, GOT_E0: make_evt  = (i_byte != 8'hE0) && (i_byte != 8'hF0);
                default:      break_evt = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (i_byte)
            8'h1C: letter_lc = "a";  8'h32: letter_lc = "b";  8'h21: letter_lc = "c";
            8'h23: letter_lc = "d";  8'h24: letter_lc = "e";  8'h2B: letter_lc = "f";
            8'h34: letter_lc = "g";  8'h33: letter_lc = "h";  8'h43: letter_lc = "i";
            8'h3B: letter_lc = "j";  8'h42: letter_lc = "k";  8'h4B: letter_lc = "l";
            8'h3A: letter_lc = "m";  8'h31: letter_lc = "n";  8'h44: letter_lc = "o";
            8'h4D: letter_lc = "p";  8'h15: letter_lc = "q";  8'h2D: letter_lc = "r";
            8'h1B: letter_lc = "s";  8'h2C: letter_lc = "t";  8'h3C: letter_lc = "u";
            8'h2A: letter_lc = "v";  8'h1D: letter_lc = "w";  8'h22: letter_lc = "x";
            8'h35: letter_lc = "y";  8'h1A: letter_lc = "z";
            default: letter_lc = 8'h00;
        endcase
    end

    always_comb begin
        xlat_hit  = 1'b0;
        xlat_char = 8'h00;
        if (evt_ext) begin
`ifdef KB_EXT_EN
            xlat_hit = 1'b1;
            case (i_byte)
                8'h75:   xlat_char = 8'h80;
                8'h72:   xlat_char = 8'h81;
                8'h6B:   xlat_char = 8'h82;
                8'h74:   xlat_char = 8'h83;
                8'h5A:   xlat_char = 8'h0D;
                8'h71:   xlat_char = 8'h7F;
                default: xlat_hit  = 1'b0;
            endcase
`endif
        end else if (letter_lc != 8'h00) begin
            xlat_hit  = 1'b1;
            xlat_char = (shift_now ^ caps_reg) ? letter_lc - 8'h20 : letter_lc;
        end else begin
            // Caps lock deliberately ignored on the digit row.
            xlat_hit = 1'b1;
            case (i_byte)
                8'h16:   xlat_char = shift_now ? "!" : "1";
                8'h1E:   xlat_char = shift_now ? "@" : "2";
                8'h26:   xlat_char = shift_now ? "#" : "3";
                8'h25:   xlat_char = shift_now ? "$" : "4";
                8'h2E:   xlat_char = shift_now ? "%" : "5";
                8'h36:   xlat_char = shift_now ? "^" : "6";
                8'h3D:   xlat_char = shift_now ? "&" : "7";
                8'h3E:   xlat_char = shift_now ? "*" : "8";
                8'h46:   xlat_char = shift_now ? "(" : "9";
                8'h45:   xlat_char = shift_now ? ")" : "0";
                8'h29:   xlat_char = 8'h20;
                8'h5A:   xlat_char = 8'h0D;
                8'h66:   xlat_char = 8'h08;
                default: xlat_hit  = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            shift_l_reg    <= 1'b0;
            shift_r_reg    <= 1'b0;
            caps_reg       <= 1'b0;
            caps_held_reg  <= 1'b0;
            char_valid_reg <= 1'b0;
            char_reg       <= 8'h00;
        end else begin
            char_valid_reg <= make_evt && xlat_hit;
            if (make_evt && xlat_hit)
                char_reg <= xlat_char;
            if (i_byte_en) begin
                case (state_reg)
                    IDLE: begin
                        if (i_byte == 8'hE0)      state_reg <= GOT_E0;
                        else if (i_byte == 8'hF0) state_reg <= GOT_F0;
                    end
                    GOT_E0: begin
                        if (i_byte == 8'hF0)      state_reg <= GOT_E0F0;
                        else if (i_byte != 8'hE0) state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
            // Extended 12/59 are the fake shifts some keys emit; leave real shift state alone.
            if ((make_evt || break_evt) && !evt_ext) begin
                case (i_byte)
                    8'h12: shift_l_reg <= make_evt;
                    8'h59: shift_r_reg <= make_evt;
                    8'h58: begin
                        if (make_evt && !caps_held_reg)
                            caps_reg <= ~caps_reg;
                        caps_held_reg <= make_evt;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign full    = (count_reg == FULL_COUNT);
    assign pop     = o_valid && i_ready;
    assign push_ok = char_valid_reg && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= char_reg;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: ;
            endcase
            if (char_valid_reg && full && !pop)
                overflow_reg <= 1'b1;
        end
    end

    assign o_valid    = (count_reg != '0);
    assign o_ascii    = o_valid ? mem[rd_ptr_reg] : 8'h00;
    assign o_count    = count_reg;
    assign o_shift    = shift_now;
    assign o_capslock = caps_reg;
    assign o_overflow = overflow_reg;
endmodule

// File: tb/tb_ps2_ascii_fifo.sv
// Bench for ps2_ascii_fifo (DEPTH=4): vector table, directed corner sequences, random traffic vs. a queue model.
module tb_ps2_ascii_fifo;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          byte_en = 1'b0;
    logic [7:0]    byte_d  = 8'h00;
    logic          ready   = 1'b0;
    logic          valid;
    logic [7:0]    ascii;
    logic [AW:0]   count;
    logic          shift;
    logic          caps;
    logic          ovf;

    ps2_ascii_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_byte_en  (byte_en),
        .i_byte     (byte_d),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_ascii    (ascii),
        .o_count    (count),
        .o_shift    (shift),
        .o_capslock (caps),
        .o_overflow (ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: keyboard state as plain flags, FIFO as a queue.
    logic [7:0] letter_code [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                     8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                     8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_code [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] digit_sym [10]   = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
    logic [7:0] ext_code [6]     = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h71};
    logic [7:0] ext_char [6]     = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h0D, 8'h7F};

    logic [7:0] m_q[$];
    bit         m_stage_v;
    logic [7:0] m_stage_c;
    bit         m_e0, m_f0, m_lsh, m_rsh, m_caps, m_held, m_ovf;

    task automatic model_reset();
        m_q.delete();
        m_stage_v = 0; m_stage_c = 8'h00;
        m_e0 = 0; m_f0 = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_held = 0; m_ovf = 0;
    endtask

    task automatic stage(input logic [7:0] c);
        m_stage_v = 1;
        m_stage_c = c;
    endtask

    task automatic model_make(input logic [7:0] b, input bit ext);
        bit sh;
        sh = m_lsh || m_rsh;
        if (ext) begin
`ifdef KB_EXT_EN
            for (int i = 0; i < 6; i++)
                if (ext_code[i] == b) stage(ext_char[i]);
`endif
        end else begin
            for (int i = 0; i < 26; i++)
                if (letter_code[i] == b) stage(8'((sh ^ m_caps) ? 65 + i : 97 + i));
            for (int i = 0; i < 10; i++)
                if (digit_code[i] == b) stage(sh ? digit_sym[i] : 8'(48 + i));
            if (b == 8'h29) stage(8'h20);
            if (b == 8'h5A) stage(8'h0D);
            if (b == 8'h66) stage(8'h08);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit ext, brk;
        if (!m_f0 && b == 8'hE0) m_e0 = 1;
        else if (!m_f0 && b == 8'hF0) m_f0 = 1;
        else begin
            ext = m_e0; brk = m_f0; m_e0 = 0; m_f0 = 0;
            if (!ext && b == 8'h12) m_lsh = !brk;
            else if (!ext && b == 8'h59) m_rsh = !brk;
            else if (!ext && b == 8'h58) begin
                if (!brk && !m_held) m_caps = !m_caps;
                m_held = !brk;
            end else if (!brk) model_make(b, ext);
        end
    endtask

    task automatic model_edge(input logic en, input logic [7:0] b, input logic rdy);
        bit pop, acc;
        pop = (m_q.size() > 0) && rdy;
        acc = 0;
        if (m_stage_v) begin
            if (m_q.size() < DEPTH || pop) acc = 1;
            else m_ovf = 1;
        end
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(m_stage_c);
        m_stage_v = 0;
        if (en) model_byte(b);
    endtask

    task automatic compare_model();
        chk("model valid",    valid, m_q.size() > 0);
        chk("model ascii",    ascii, m_q.size() > 0 ? m_q[0] : 8'h00);
        chk("model count",    count, m_q.size());
        chk("model shift",    shift, m_lsh || m_rsh);
        chk("model caps",     caps,  m_caps);
        chk("model overflow", ovf,   m_ovf);
    endtask

    task automatic step(input logic en, input logic [7:0] b, input logic rdy);
        byte_en = en; byte_d = b; ready = rdy;
        @(posedge clk);
        cyc++;
        model_edge(en, b, rdy);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic       en;
        logic [7:0] b;
        logic       rdy;
        logic       v;
        logic [7:0] a;
        int         c;
        logic       s;
        logic       k;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic en, input logic [7:0] b, input logic rdy, input logic v,
                       input logic [7:0] a, input int c, input logic s, input logic k);
        vec_t t;
        t.en = en; t.b = b; t.rdy = rdy; t.v = v; t.a = a; t.c = c; t.s = s; t.k = k;
        vecs.push_back(t);
    endtask

    logic [7:0] pool [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h16, 8'h1E, 8'h45, 8'h46,
                              8'h12, 8'h59, 8'h58, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h29, 8'h5A, 8'h66,
                              8'h75, 8'h72, 8'h6B, 8'h71, 8'h0E, 8'h00};

    initial begin
        logic [7:0] exp_q[$];

        // Make/break/pop; shifted letter; caps toggling, typematic, digits unaffected by caps.
        add(1,8'h1C,0, 0,8'h00,0,0,0); add(1,8'hF0,0, 1,8'h61,1,0,0); add(1,8'h1C,0, 1,8'h61,1,0,0);
        add(0,8'h00,0, 1,8'h61,1,0,0); add(0,8'h00,1, 0,8'h00,0,0,0);
        add(1,8'h12,0, 0,8'h00,0,1,0); add(1,8'h1C,0, 0,8'h00,0,1,0); add(1,8'hF0,0, 1,8'h41,1,1,0);
        add(1,8'h12,0, 1,8'h41,1,0,0); add(1,8'h1C,0, 1,8'h41,1,0,0); add(0,8'h00,0, 1,8'h41,2,0,0);
        add(0,8'h00,1, 1,8'h61,1,0,0); add(0,8'h00,1, 0,8'h00,0,0,0);
        add(1,8'h58,0, 0,8'h00,0,0,1); add(1,8'hF0,0, 0,8'h00,0,0,1); add(1,8'h58,0, 0,8'h00,0,0,1);
        add(1,8'h58,0, 0,8'h00,0,0,0); add(1,8'h58,0, 0,8'h00,0,0,0); add(1,8'hF0,0, 0,8'h00,0,0,0);
        add(1,8'h58,0, 0,8'h00,0,0,0); add(1,8'h12,0, 0,8'h00,0,1,0); add(1,8'h1C,0, 0,8'h00,0,1,0);
        add(1,8'h16,0, 1,8'h41,1,1,0); add(0,8'h00,1, 1,8'h21,1,1,0); add(1,8'hF0,1, 0,8'h00,0,1,0);
        add(1,8'h12,0, 0,8'h00,0,0,0);
        add(1,8'h58,0, 0,8'h00,0,0,1); add(1,8'hF0,0, 0,8'h00,0,0,1); add(1,8'h58,0, 0,8'h00,0,0,1);
        add(1,8'h1C,0, 0,8'h00,0,0,1); add(1,8'h16,0, 1,8'h41,1,0,1); add(1,8'h12,0, 1,8'h41,2,1,1);
        add(1,8'h1C,0, 1,8'h41,2,1,1); add(0,8'h00,0, 1,8'h41,3,1,1); add(0,8'h00,1, 1,8'h31,2,1,1);
        add(0,8'h00,1, 1,8'h61,1,1,1); add(0,8'h00,1, 0,8'h00,0,1,1); add(1,8'hF0,0, 0,8'h00,0,1,1);
        add(1,8'h12,0, 0,8'h00,0,0,1); add(1,8'h58,0, 0,8'h00,0,0,0); add(1,8'hF0,0, 0,8'h00,0,0,0);
        add(1,8'h58,0, 0,8'h00,0,0,0);

        model_reset();
        #22;
        chk("reset valid", valid, 0); chk("reset ascii", ascii, 0); chk("reset count", count, 0);
        chk("reset shift", shift, 0); chk("reset caps", caps, 0);   chk("reset overflow", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].b, vecs[i].rdy);
            chk($sformatf("vec[%0d] valid", i), valid, vecs[i].v);
            chk($sformatf("vec[%0d] ascii", i), ascii, vecs[i].a);
            chk($sformatf("vec[%0d] count", i), count, vecs[i].c);
            chk($sformatf("vec[%0d] shift", i), shift, vecs[i].s);
            chk($sformatf("vec[%0d] caps",  i), caps,  vecs[i].k);
        end

        // Overflow: five pushes into a 4-deep FIFO, then a push that coincides with a pop.
        for (int i = 0; i < 5; i++) step(1, 8'h1C, 0);
        step(0, 8'h00, 0);
        chk("full count", count, DEPTH);
        chk("full overflow", ovf, 1);
        step(1, 8'h1C, 0);
        step(0, 8'h00, 1);
        chk("push+pop when full count", count, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain[%0d] ascii", i), ascii, 8'h61);
            step(0, 8'h00, 1);
        end
        chk("drained valid", valid, 0);
        chk("overflow sticky", ovf, 1);

        // Extended make/break followed by space.
        step(1, 8'hE0, 0); step(1, 8'h75, 0); step(1, 8'hE0, 0); step(1, 8'hF0, 0);
        step(1, 8'h75, 0); step(1, 8'h29, 0); step(0, 8'h00, 0); step(0, 8'h00, 0);
`ifdef KB_EXT_EN
        exp_q = '{8'h80, 8'h20};
`else
        exp_q = '{8'h20};
`endif
        chk("ext count", count, exp_q.size());
        foreach (exp_q[i]) begin
            chk($sformatf("ext[%0d] ascii", i), ascii, exp_q[i]);
            step(0, 8'h00, 1);
        end
        chk("ext drained valid", valid, 0);

        // Asynchronous reset with a pending E0 prefix and buffered data.
        step(1, 8'h12, 0); step(1, 8'h1C, 0); step(1, 8'hE0, 0);
        chk("pre-reset count", count, 1);
        #3;
        rst_n = 1'b0;
        byte_en = 1'b0;
        #1;
        chk("async reset valid", valid, 0); chk("async reset ascii", ascii, 0);
        chk("async reset count", count, 0); chk("async reset shift", shift, 0);
        chk("async reset caps", caps, 0);   chk("async reset overflow", ovf, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 8'h1C, 0);
        step(0, 8'h00, 0);
        chk("post-reset ascii", ascii, 8'h61);
        chk("post-reset count", count, 1);
        step(0, 8'h00, 1);

        // Random traffic: slow consumer first, then a fast one.
        for (int i = 0; i < 900; i++) begin
            logic en, rdy;
            en  = ($urandom_range(0, 3) != 0);
            rdy = (i < 450) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(en, pool[$urandom_range(0, 25)], rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
